// File: rtl/uart_core_if.sv
// Handshake bundle between the CPU-side UART register block and uart_core.
// master = register block side, slave = uart_core.
interface uart_core_if #(
  parameter int DataBits = 8
);
  logic                tx_valid;
  logic                tx_ready;
  logic [DataBits-1:0] tx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic [DataBits-1:0] rx_data;
  logic                rx_parity_err;
  logic                rx_frame_err;
  logic                rx_overrun;
  logic                overrun_clr;

  modport master (
    output tx_valid, tx_data, rx_ready, overrun_clr,
    input  tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun
  );
  modport slave (
    input  tx_valid, tx_data, rx_ready, overrun_clr,
    output tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART: run-time baud divisor, optional parity, 1/2 stop bits,
// parity/framing error detection and a sticky overrun flag on the RX side.
module uart_core #(
  parameter int DataBits     = 8,
  parameter int DivWidth     = 16,
  parameter int RxSyncStages = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DivWidth-1:0] i_div,
  input  logic                i_parity_en,
  input  logic                i_parity_odd,
  input  logic                i_two_stop,
  output logic                o_tx,
  input  logic                i_rx,
  uart_core_if.slave          bus
);
  localparam int BitW = $clog2(DataBits);
  localparam logic [BitW-1:0] LastBit = BitW'(DataBits - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic [DivWidth-1:0] sat_div(input logic [DivWidth-1:0] d);
    return (d < DivWidth'(3)) ? DivWidth'(3) : d;
  endfunction

  function automatic logic par_bit(input logic [DataBits-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Start-bit centre offset: (div+1)/2 - 1, computed one bit wider to avoid wrap.
  function automatic logic [DivWidth-1:0] half_cnt(input logic [DivWidth-1:0] d);
    logic [DivWidth:0] h;
    h = ({1'b0, d} + (DivWidth+1)'(1)) >> 1;
    return DivWidth'(h - (DivWidth+1)'(1));
  endfunction

  // ---------------- transmitter ----------------
  logic [2:0]          tx_st_q, tx_st_d;
  logic [DivWidth-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [BitW-1:0]     tx_bit_q, tx_bit_d;
  logic [DataBits-1:0] tx_sh_q, tx_sh_d;
  logic                tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_two_q, tx_two_d;
  logic                tx_line_q, tx_line_d;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q - DivWidth'(1);
    tx_div_d  = tx_div_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_pen_d  = tx_pen_q;
    tx_two_d  = tx_two_q;
    tx_line_d = tx_line_q;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d  = tx_cnt_q;
        tx_line_d = 1'b1;
        if (bus.tx_valid) begin
          tx_div_d  = sat_div(i_div);
          tx_cnt_d  = sat_div(i_div);
          tx_sh_d   = bus.tx_data;
          tx_par_d  = par_bit(bus.tx_data, i_parity_odd);
          tx_pen_d  = i_parity_en;
          tx_two_d  = i_two_stop;
          tx_line_d = 1'b0;
          tx_st_d   = S_START;
        end
      end
      S_START: if (tx_cnt_q == '0) begin
        tx_cnt_d  = tx_div_q;
        tx_line_d = tx_sh_q[0];
        tx_sh_d   = tx_sh_q >> 1;
        tx_bit_d  = '0;
        tx_st_d   = S_DATA;
      end
      S_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = tx_div_q;
        if (tx_bit_q == LastBit) begin
          tx_line_d = tx_pen_q ? tx_par_q : 1'b1;
          tx_st_d   = tx_pen_q ? S_PARITY : S_STOP;
        end else begin
          tx_line_d = tx_sh_q[0];
          tx_sh_d   = tx_sh_q >> 1;
          tx_bit_d  = tx_bit_q + BitW'(1);
        end
      end
      S_PARITY: if (tx_cnt_q == '0) begin
        tx_cnt_d  = tx_div_q;
        tx_line_d = 1'b1;
        tx_st_d   = S_STOP;
      end
      // tx_two_q doubles as "one more stop bit to send"
      S_STOP: if (tx_cnt_q == '0) begin
        if (tx_two_q) begin
          tx_two_d = 1'b0;
          tx_cnt_d = tx_div_q;
        end else begin
          tx_st_d = S_IDLE;
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_st_q   <= S_IDLE;
      tx_line_q <= 1'b1;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_line_q <= tx_line_d;
    end
    tx_cnt_q <= tx_cnt_d;
    tx_div_q <= tx_div_d;
    tx_bit_q <= tx_bit_d;
    tx_sh_q  <= tx_sh_d;
    tx_par_q <= tx_par_d;
    tx_pen_q <= tx_pen_d;
    tx_two_q <= tx_two_d;
  end

  assign o_tx         = tx_line_q;
  assign bus.tx_ready = (tx_st_q == S_IDLE);

  // ---------------- receiver ----------------
  logic [RxSyncStages-1:0] sync_q;
  logic                    prev_q, rx_s;
  logic [2:0]              rx_st_q, rx_st_d;
  logic [DivWidth-1:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [BitW-1:0]         rx_bit_q, rx_bit_d;
  logic [DataBits-1:0]     rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                    rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
  logic                    vld_q, vld_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  assign rx_s = sync_q[RxSyncStages-1];

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q - DivWidth'(1);
    rx_div_d  = rx_div_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_pen_d  = rx_pen_q;
    rx_odd_d  = rx_odd_q;
    rx_perr_d = rx_perr_q;
    rx_data_d = rx_data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    vld_d     = vld_q && !bus.rx_ready;
    ovr_d     = ovr_q && !bus.overrun_clr;
    case (rx_st_q)
      // prev_q must be high, so a line still low after a bad stop bit is ignored
      S_IDLE: begin
        rx_cnt_d = rx_cnt_q;
        if (prev_q && !rx_s) begin
          rx_div_d  = sat_div(i_div);
          rx_cnt_d  = half_cnt(sat_div(i_div));
          rx_pen_d  = i_parity_en;
          rx_odd_d  = i_parity_odd;
          rx_perr_d = 1'b0;
          rx_st_d   = S_START;
        end
      end
      S_START: if (rx_cnt_q == '0) begin
        rx_cnt_d = rx_div_q;
        rx_bit_d = '0;
        rx_st_d  = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == '0) begin
        rx_cnt_d = rx_div_q;
        rx_sh_d  = {rx_s, rx_sh_q[DataBits-1:1]};
        rx_bit_d = rx_bit_q + BitW'(1);
        if (rx_bit_q == LastBit) rx_st_d = rx_pen_q ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_cnt_q == '0) begin
        rx_cnt_d  = rx_div_q;
        rx_perr_d = (rx_s != par_bit(rx_sh_q, rx_odd_q));
        rx_st_d   = S_STOP;
      end
      S_STOP: if (rx_cnt_q == '0) begin
        rx_st_d   = S_IDLE;
        rx_data_d = rx_sh_q;
        perr_d    = rx_perr_q;
        ferr_d    = !rx_s;
        vld_d     = 1'b1;
        if (vld_q && !bus.rx_ready) ovr_d = 1'b1;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q    <= '1;
      prev_q    <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_data_q <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[RxSyncStages-2:0], i_rx};
      prev_q    <= rx_s;
      rx_st_q   <= rx_st_d;
      rx_data_q <= rx_data_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
    rx_cnt_q  <= rx_cnt_d;
    rx_div_q  <= rx_div_d;
    rx_bit_q  <= rx_bit_d;
    rx_sh_q   <= rx_sh_d;
    rx_pen_q  <= rx_pen_d;
    rx_odd_q  <= rx_odd_d;
    rx_perr_q <= rx_perr_d;
  end

  assign bus.rx_valid      = vld_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_parity_err = perr_q;
  assign bus.rx_frame_err  = ferr_q;
  assign bus.rx_overrun    = ovr_q;
endmodule
